// File: rtl/ififo16_pkg.sv
// rtl/ififo16_pkg.sv - shared constants and helpers for the 16-entry FIFO
package ififo16_pkg;

  // Geometry of the queue: 16 slots, 4-bit pointers, 5-bit occupancy (0..16)
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 5;

  // Occupancy values at which the flags assert
  localparam logic [CNT_W-1:0] CNT_EMPTY = '0;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  // Queue operation resolved for one cycle after the full/empty gating
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Pointer advance; the 4-bit width makes 15 -> 0 wrap implicit
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/ififo16_mem.sv
// rtl/ififo16_mem.sv - 16 x P_WIDTH register array, sync write, async read
module ififo16_mem
  import ififo16_pkg::*;
#(
  parameter int P_WIDTH = 128
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [PTR_W-1:0]   i_waddr,
  input  logic [P_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]   i_raddr,
  output logic [P_WIDTH-1:0] o_rdata
);

  // Storage is deliberately not reset; the empty flag masks stale contents
  logic [P_WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed slot on an accepted enqueue
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ififo16.sv
// rtl/ififo16.sv - 16-entry first-word fall-through FIFO; IFIFO16_COUNT_EN adds o_count
module ififo16
  import ififo16_pkg::*;
#(
  parameter int P_WIDTH = 128
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [P_WIDTH-1:0] i_data,
  output logic [P_WIDTH-1:0] o_data,
  input  logic               i_enq,
  input  logic               i_deq,
  output logic               o_full,
  output logic               o_empty
`ifdef IFIFO16_COUNT_EN
  ,
  output logic [CNT_W-1:0]   o_count
`endif
);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               enq_ok;
  logic               deq_ok;
  fifo_op_e           op;
  logic [P_WIDTH-1:0] rd_data;

  // Flags decode registered occupancy only, so no input reaches them combinationally
  assign o_full  = (count_q == CNT_FULL);
  assign o_empty = (count_q == CNT_EMPTY);

  // Gate requests: a push into a full queue is dropped even if a pop happens too
  assign enq_ok = i_enq & ~o_full;
  assign deq_ok = i_deq & ~o_empty;
  assign op     = fifo_op_e'({enq_ok, deq_ok});

  // Next pointers and occupancy for the resolved operation
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OP_PUSH: begin
        wr_ptr_d = ptr_next(wr_ptr_q);
        count_d  = count_q + CNT_W'(1);
      end
      OP_POP: begin
        rd_ptr_d = ptr_next(rd_ptr_q);
        count_d  = count_q - CNT_W'(1);
      end
      OP_BOTH: begin
        wr_ptr_d = ptr_next(wr_ptr_q);
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      default: begin
      end
    endcase
  end

  // Pointer/occupancy registers; reset wins over any concurrent request
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ififo16_mem #(
    .P_WIDTH (P_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (enq_ok & i_rst_n),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_data)
  );

  // Head word falls through; zero while empty so stale storage never shows
  assign o_data = o_empty ? '0 : rd_data;

`ifdef IFIFO16_COUNT_EN
  assign o_count = count_q;
`endif

endmodule

// File: tb/tb_ififo16.sv
// tb/tb_ififo16.sv - directed and model-checked bench for ififo16 (honours IFIFO16_COUNT_EN)
module tb_ififo16;

  logic         clk;
  logic         rst_n;
  logic [127:0] din;
  logic         enq;
  logic         deq;
  logic [127:0] dout;
  logic [7:0]   dout8;
  logic         full, empty, full8, empty8;
`ifdef IFIFO16_COUNT_EN
  logic [4:0]   count, count8;
`endif

  int n_chk;
  int n_err;
  logic [127:0] mq[$];

  ififo16 #(.P_WIDTH(128)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (din),
    .o_data  (dout),
    .i_enq   (enq),
    .i_deq   (deq),
    .o_full  (full),
    .o_empty (empty)
`ifdef IFIFO16_COUNT_EN
    ,
    .o_count (count)
`endif
  );

  ififo16 #(.P_WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (din[7:0]),
    .o_data  (dout8),
    .i_enq   (enq),
    .i_deq   (deq),
    .o_full  (full8),
    .o_empty (empty8)
`ifdef IFIFO16_COUNT_EN
    ,
    .o_count (count8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int exp);
`ifdef IFIFO16_COUNT_EN
    check(tag, 128'(count), 128'(exp));
    check({tag, "_w8"}, 128'(count8), 128'(exp));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      enq = 1'b1;
      din = 128'(base + i);
      step();
    end
    enq = 1'b0;
  endtask

  task automatic pop_expect(input int n, input int base, input string tag);
    deq = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, dout, 128'(base + i));
      step();
    end
    deq = 1'b0;
  endtask

  initial begin
    logic acc_e, acc_d;
    logic [127:0] exp_head;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    enq   = 1'b0;
    deq   = 1'b0;
    din   = '0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_data", dout, 0);
    check_cnt("rst_count", 0);

    // Fill with 1..16, then a dropped 99, then drain in order
    push_n(15, 1);
    check("fill15_full", full, 1'b0);
    check("fill15_head", dout, 1);
    push_n(1, 16);
    check("fill16_full", full, 1'b1);
    check_cnt("fill16_count", 16);
    enq = 1'b1;
    din = 99;
    step();
    enq = 1'b0;
    check("drop99_full", full, 1'b1);
    check("drop99_head", dout, 1);
    pop_expect(16, 1, "drain_order");
    check("drain_empty", empty, 1'b1);
    check("drain_data", dout, 0);
    check("drain_full", full, 1'b0);

    // No same-cycle bypass, one-cycle latency, pop back to empty
    enq = 1'b1;
    din = 128'hA5;
    #1;
    check("a5_nobypass_empty", empty, 1'b1);
    check("a5_nobypass_data", dout, 0);
    step();
    enq = 1'b0;
    check("a5_data", dout, 128'hA5);
    check("a5_empty", empty, 1'b0);
    deq = 1'b1;
    step();
    deq = 1'b0;
    check("a5_pop_empty", empty, 1'b1);
    deq = 1'b1;
    step();
    deq = 1'b0;
    check("pop_when_empty", empty, 1'b1);
    check_cnt("pop_when_empty_count", 0);

    // Occupancy 5 with 20 simultaneous push/pop cycles across pointer wrap
    push_n(5, 100);
    enq = 1'b1;
    deq = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = 128'(105 + k);
      check("wrap_head", dout, 128'(100 + k));
      step();
    end
    enq = 1'b0;
    deq = 1'b0;
    check_cnt("wrap_count", 5);
    check("wrap_full", full, 1'b0);
    check("wrap_empty", empty, 1'b0);
    pop_expect(5, 120, "wrap_drain");
    check("wrap_drain_empty", empty, 1'b1);

    // Full with both requests: one pop, nothing written
    push_n(16, 200);
    enq = 1'b1;
    deq = 1'b1;
    din = 77;
    step();
    enq = 1'b0;
    deq = 1'b0;
    check("full_both_full", full, 1'b0);
    check("full_both_head", dout, 201);
    check_cnt("full_both_count", 15);
    pop_expect(15, 201, "full_both_drain");
    check("full_both_empty", empty, 1'b1);
    check("full_both_data", dout, 0);

    // Reset at occupancy 7 with enqueue asserted
    push_n(7, 300);
    check_cnt("pre_rst_count", 7);
    rst_n = 1'b0;
    enq   = 1'b1;
    din   = 55;
    step();
    rst_n = 1'b1;
    enq   = 1'b0;
    check("rst7_empty", empty, 1'b1);
    check("rst7_full", full, 1'b0);
    check("rst7_data", dout, 0);
    check_cnt("rst7_count", 0);

    // Random traffic against a queue model, both widths
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      enq = ($urandom_range(0, 99) < 55);
      deq = ($urandom_range(0, 99) < 50);
      din = {$urandom, $urandom, $urandom, $urandom};
      acc_e = enq && (mq.size() < 16);
      acc_d = deq && (mq.size() > 0);
      step();
      if (acc_d) void'(mq.pop_front());
      if (acc_e) mq.push_back(din);
      exp_head = (mq.size() > 0) ? mq[0] : '0;
      check("rnd_data", dout, exp_head);
      check("rnd_data_w8", 128'(dout8), 128'(exp_head[7:0]));
      check("rnd_full", full, mq.size() == 16);
      check("rnd_empty", empty, mq.size() == 0);
      check("rnd_full_w8", full8, mq.size() == 16);
      check("rnd_empty_w8", empty8, mq.size() == 0);
      check_cnt("rnd_count", mq.size());
    end
    enq = 1'b0;
    deq = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
